memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
- Sole owner of the byte-wide RAM/IO port; sits directly downstream of load_store_buffer and beside the instruction fetcher.
- Arbitrates three requesters: committed stores, loads and instruction fetch. Serialises each access into 1/2/4 single-byte RAM transactions.
- Returns a one-cycle finish pulse plus assembled data to the requester.

Parameters:
- IO_ADDR_HI, 2'b11, value of address bits [17:16] that selects the IO region, where writes obey io_buffer_full.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  ready; low freezes all state
- roll_back  input  1  mispredict flush
- if_req  input  1  fetch request, level, held until if_done
- if_addr  input  32  fetch address
- if_done  output  1  fetch finish pulse
- if_inst  output  32  fetched word
- lsb_load  input  1  load request, level
- load_address  input  32  load address
- op_type_load  input  6  LB/LH/LW/LBU/LHU code
- finish_load  output  1  load finish pulse
- data_load  output  32  extended load data
- lsb_store  input  1  store request, level
- store_address  input  32  store address
- data_store  input  32  store data
- op_type_store  input  6  SB/SH/SW code
- finish_store  output  1  store finish pulse
- mem_din  input  8  RAM read byte, valid one cycle after mem_a
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write
- io_buffer_full  input  1  IO write buffer full

Behaviour:
- States: IDLE, READ, WRITE, DONE. Registers: owner (FETCH/LOAD/STORE), base address, byte count n (1/2/4), index cnt, 32-bit assembly buffer.
- Reset: all outputs 0, state IDLE. This includes if_done, finish_load, finish_store, mem_wr, mem_a, mem_dout, data_load and if_inst.
- rdy_in low: no register changes, including cnt and the finish pulses.
- IDLE acceptance: priority store > load > fetch. On the accepting edge:
  - Latch owner, address, size and data.
  - READ: drive mem_a=addr, cnt=0.
  - WRITE: drive mem_a=addr, mem_dout=byte0, mem_wr=1.
- READ:
  - On edge k (k=1..n) capture mem_din into byte k-1 (little-endian).
  - While k<n, drive mem_a=addr+k.
  - On edge n: pulse the owner's finish for 1 cycle with the assembled value, set state DONE.
  - Read latency is n+1 cycles from the request being seen in IDLE to the finish pulse.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. Fetch always reads 4 bytes.
- WRITE:
  - Each edge advances one byte: mem_a=addr+cnt, mem_dout=byte cnt, mem_wr=1.
  - After the last byte, the next edge sets mem_wr=0, pulses finish_store and sets state DONE.
  - If addr[17:16]==IO_ADDR_HI and io_buffer_full=1: hold mem_wr=0 and do not advance cnt until full drops.
- DONE: lasts exactly 1 cycle; requests are ignored, then state returns to IDLE. This covers requesters that drop their level one cycle after finish.
- mem_wr is 0 in every state except byte-issue cycles of WRITE.
- roll_back:
  - In READ with any owner: abort immediately, no finish pulse, state IDLE.
  - In IDLE/DONE: no action.
  - In WRITE: ignored; committed stores always complete.
- Requests arriving in the same cycle as roll_back are not accepted.
- Address arithmetic wraps at 32 bits. Misaligned accesses are serviced byte-wise without faulting.

Decomposition:
- LB/LH/LW/LBU/LHU/SB/SH/SW op codes belong in operaType.v next to the existing type constants. Add state and owner encodings there too (MC_IDLE..MC_DONE, OWN_FETCH/LOAD/STORE).
- One natural sub-module, mem_load_extend: combinational size/sign extension of the assembled buffer.

Test Plan:
- LW at 0x100 with RAM bytes 0x11,0x22,0x33,0x44 -> mem_a steps 0x100..0x103; finish_load pulses exactly 5 cycles after request, data_load=0x44332211.
- LB at 0x200 with byte 0x80 -> data_load=0xFFFFFF80; LBU at same address -> 0x00000080; LH with bytes 0x34,0x92 -> 0xFFFF9234.
- SW of 0xDEADBEEF to 0x40 with lsb_load and if_req also high -> store wins. mem_wr=1 for 4 cycles writing EF,BE,AD,DE; then finish_store; one DONE cycle; load served next.
- SB to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for those cycles; byte written on the cycle full drops; finish_store follows.
- roll_back at cycle 2 of a fetch READ -> no if_done, IDLE next cycle. roll_back during a SW -> all 4 bytes still written and finish_store pulses.
- rdy_in low for 2 cycles mid-LW -> mem_a and cnt frozen; finish_load delayed by exactly 2 cycles with correct data.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared encodings for the byte-wide memory controller: load/store op codes,
// controller state and bus-owner encodings, and the access-size helper.
// No ports; imported by memory_controller and mem_load_extend.
package memory_controller_pkg;

    // Value of address bits [17:16] that selects the IO region.
    localparam logic [1:0] MC_IO_ADDR_HI = 2'b11;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_e;

    typedef enum logic [1:0] {
        OWN_FETCH = 2'd0,
        OWN_LOAD  = 2'd1,
        OWN_STORE = 2'd2
    } mc_owner_e;

    // Number of RAM byte transactions an op needs; unknown codes move a word.
    function automatic logic [2:0] op_bytes(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
            default:              op_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Size/sign extension of an assembled little-endian load buffer.
// Purely combinational, no backpressure.
// Ports: op_type (load op code), raw (assembled bytes), ext (extended result).
module mem_load_extend
    import memory_controller_pkg::*;
(
    input  logic [5:0]  op_type,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (op_type)
            OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            OP_LBU:  ext = {24'd0, raw[7:0]};
            OP_LHU:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/memory_controller.sv
// Byte-serial RAM/IO port owner arbitrating store > load > fetch; returns a
// one-cycle finish pulse with assembled data. Reads finish n+1 cycles after
// acceptance-cycle request, writes likewise; rdy_in low freezes everything,
// IO-region writes stall while io_buffer_full is high.
// Ports: clk_in/rst_in/rdy_in/roll_back control; if_*, lsb_load/*_load,
// lsb_store/*_store requester interfaces; mem_* RAM port; io_buffer_full.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = MC_IO_ADDR_HI
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        lsb_load,
    input  logic [31:0] load_address,
    input  logic [5:0]  op_type_load,
    output logic        finish_load,
    output logic [31:0] data_load,
    input  logic        lsb_store,
    input  logic [31:0] store_address,
    input  logic [31:0] data_store,
    input  logic [5:0]  op_type_store,
    output logic        finish_store,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mc_state_e   state, state_nxt;
    mc_owner_e   owner, owner_nxt;
    logic [31:0] base_addr, base_addr_nxt;
    logic [2:0]  size_q, size_nxt;
    logic [2:0]  cnt, cnt_nxt, cnt_inc;
    logic [31:0] asm_q, asm_nxt, asm_cur;
    logic [31:0] store_q, store_nxt;
    logic [5:0]  op_q, op_nxt;
    logic [7:0]  store_byte;
    logic [31:0] ext_data;

    logic [31:0] mem_a_nxt;
    logic [7:0]  mem_dout_nxt;
    logic        mem_wr_nxt;
    logic        if_done_nxt, finish_load_nxt, finish_store_nxt;
    logic [31:0] if_inst_nxt, data_load_nxt;
    logic        new_store_blocked, cur_store_blocked;

    assign cnt_inc = cnt + 3'd1;
    assign new_store_blocked = (store_address[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign cur_store_blocked = (base_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

    // Buffer as it will look once the byte on mem_din this cycle is merged in;
    // the finishing edge publishes this, not the stale registered copy.
    always_comb begin
        asm_cur = asm_q;
        case (cnt[1:0])
            2'd0:    asm_cur[7:0]   = mem_din;
            2'd1:    asm_cur[15:8]  = mem_din;
            2'd2:    asm_cur[23:16] = mem_din;
            default: asm_cur[31:24] = mem_din;
        endcase
    end

    always_comb begin
        store_byte = store_q[7:0];
        case (cnt[1:0])
            2'd0:    store_byte = store_q[7:0];
            2'd1:    store_byte = store_q[15:8];
            2'd2:    store_byte = store_q[23:16];
            default: store_byte = store_q[31:24];
        endcase
    end

    mem_load_extend u_load_extend (
        .op_type (op_q),
        .raw     (asm_cur),
        .ext     (ext_data)
    );

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        base_addr_nxt    = base_addr;
        size_nxt         = size_q;
        cnt_nxt          = cnt;
        asm_nxt          = asm_q;
        store_nxt        = store_q;
        op_nxt           = op_q;
        mem_a_nxt        = mem_a;
        mem_dout_nxt     = mem_dout;
        mem_wr_nxt       = 1'b0;
        if_done_nxt      = 1'b0;
        finish_load_nxt  = 1'b0;
        finish_store_nxt = 1'b0;
        if_inst_nxt      = if_inst;
        data_load_nxt    = data_load;

        case (state)
            MC_IDLE: begin
                if (!roll_back) begin
                    if (lsb_store) begin
                        owner_nxt     = OWN_STORE;
                        base_addr_nxt = store_address;
                        size_nxt      = op_bytes(op_type_store);
                        store_nxt     = data_store;
                        mem_a_nxt     = store_address;
                        state_nxt     = MC_WRITE;
                        // cnt counts bytes already issued on the bus.
                        if (new_store_blocked) begin
                            cnt_nxt = 3'd0;
                        end else begin
                            mem_dout_nxt = data_store[7:0];
                            mem_wr_nxt   = 1'b1;
                            cnt_nxt      = 3'd1;
                        end
                    end else if (lsb_load) begin
                        owner_nxt     = OWN_LOAD;
                        base_addr_nxt = load_address;
                        size_nxt      = op_bytes(op_type_load);
                        op_nxt        = op_type_load;
                        mem_a_nxt     = load_address;
                        cnt_nxt       = 3'd0;
                        state_nxt     = MC_READ;
                    end else if (if_req) begin
                        owner_nxt     = OWN_FETCH;
                        base_addr_nxt = if_addr;
                        size_nxt      = 3'd4;
                        mem_a_nxt     = if_addr;
                        cnt_nxt       = 3'd0;
                        state_nxt     = MC_READ;
                    end
                end
            end

            MC_READ: begin
                if (roll_back) begin
                    state_nxt = MC_IDLE;
                end else begin
                    asm_nxt = asm_cur;
                    if (cnt_inc == size_q) begin
                        state_nxt = MC_DONE;
                        if (owner == OWN_LOAD) begin
                            finish_load_nxt = 1'b1;
                            data_load_nxt   = ext_data;
                        end else begin
                            if_done_nxt = 1'b1;
                            if_inst_nxt = asm_cur;
                        end
                    end else begin
                        cnt_nxt   = cnt_inc;
                        mem_a_nxt = base_addr + {29'd0, cnt_inc};
                    end
                end
            end

            MC_WRITE: begin
                // Committed stores complete regardless of roll_back.
                if (cnt == size_q) begin
                    finish_store_nxt = 1'b1;
                    state_nxt        = MC_DONE;
                end else if (!cur_store_blocked) begin
                    mem_a_nxt    = base_addr + {29'd0, cnt};
                    mem_dout_nxt = store_byte;
                    mem_wr_nxt   = 1'b1;
                    cnt_nxt      = cnt_inc;
                end
            end

            // One dead cycle so a requester dropping its level after the
            // finish pulse is not re-accepted.
            MC_DONE: state_nxt = MC_IDLE;

            default: state_nxt = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= MC_IDLE;
            owner        <= OWN_FETCH;
            base_addr    <= 32'd0;
            size_q       <= 3'd0;
            cnt          <= 3'd0;
            asm_q        <= 32'd0;
            store_q      <= 32'd0;
            op_q         <= 6'd0;
            mem_a        <= 32'd0;
            mem_dout     <= 8'd0;
            mem_wr       <= 1'b0;
            if_done      <= 1'b0;
            finish_load  <= 1'b0;
            finish_store <= 1'b0;
            if_inst      <= 32'd0;
            data_load    <= 32'd0;
        end else if (rdy_in) begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            base_addr    <= base_addr_nxt;
            size_q       <= size_nxt;
            cnt          <= cnt_nxt;
            asm_q        <= asm_nxt;
            store_q      <= store_nxt;
            op_q         <= op_nxt;
            mem_a        <= mem_a_nxt;
            mem_dout     <= mem_dout_nxt;
            mem_wr       <= mem_wr_nxt;
            if_done      <= if_done_nxt;
            finish_load  <= finish_load_nxt;
            finish_store <= finish_store_nxt;
            if_inst      <= if_inst_nxt;
            data_load    <= data_load_nxt;
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: a behavioural byte RAM feeds
// mem_din combinationally from mem_a, a write log records every issued byte,
// and expected load data/latencies come from an arithmetic reference model.
module tb_memory_controller;
    import memory_controller_pkg::*;

    localparam int          RAM_SZ   = 262144;
    localparam logic [31:0] RAM_MASK = 32'h0003FFFF;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, roll_back;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        lsb_load;
    logic [31:0] load_address;
    logic [5:0]  op_type_load;
    logic        finish_load;
    logic [31:0] data_load;
    logic        lsb_store;
    logic [31:0] store_address, data_store;
    logic [5:0]  op_type_store;
    logic        finish_store;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:RAM_SZ-1];
    logic [31:0] wr_a_log [$];
    logic [7:0]  wr_d_log [$];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [5:0] load_ops  [5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    logic [5:0] store_ops [3] = '{OP_SB, OP_SH, OP_SW};

    memory_controller dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .roll_back      (roll_back),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_inst        (if_inst),
        .lsb_load       (lsb_load),
        .load_address   (load_address),
        .op_type_load   (op_type_load),
        .finish_load    (finish_load),
        .data_load      (data_load),
        .lsb_store      (lsb_store),
        .store_address  (store_address),
        .data_store     (data_store),
        .op_type_store  (op_type_store),
        .finish_store   (finish_store),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    assign mem_din = ram[mem_a[17:0]];

    always @(posedge clk_in) begin
        if (!rst_in && rdy_in && mem_wr) begin
            wr_a_log.push_back(mem_a);
            wr_d_log.push_back(mem_dout);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [17:0] ram_idx(input logic [31:0] a);
        logic [31:0] m;
        m = a & RAM_MASK;
        return m[17:0];
    endfunction

    function automatic int op_len(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    // Little-endian value of nb bytes, optionally reinterpreted as signed.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input int nb, input bit sgn);
        longint v;
        v = 0;
        for (int i = 0; i < nb; i++)
            v = v + (longint'(ram[ram_idx(addr + 32'(i))]) << (8 * i));
        if (sgn && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    task automatic run_load(input logic [31:0] addr, input logic [5:0] op, input string tag);
        int nb;
        int cyc;
        bit got;
        logic [31:0] exp;
        nb  = op_len(op);
        cyc = 0;
        got = 0;
        exp = model_load(addr, nb, (op == OP_LB || op == OP_LH));
        lsb_load = 1'b1; load_address = addr; op_type_load = op;
        while (!got && cyc < 40) begin step(); cyc++; got = finish_load; end
        lsb_load = 1'b0;
        tests_run++;
        if (!got || cyc != nb + 1) begin
            tests_failed++;
            $display("FAIL %s load latency: got %0d cycles (seen=%0b) expected %0d", tag, cyc, got, nb + 1);
        end
        tests_run++;
        if (data_load !== exp) begin
            tests_failed++;
            $display("FAIL %s load data: got %h expected %h", tag, data_load, exp);
        end
        step();
        tests_run++;
        if (finish_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s finish_load width: got %b expected 0", tag, finish_load);
        end
    endtask

    task automatic run_fetch(input logic [31:0] addr, input string tag);
        int cyc;
        bit got;
        logic [31:0] exp;
        cyc = 0;
        got = 0;
        exp = model_load(addr, 4, 1'b0);
        if_req = 1'b1; if_addr = addr;
        while (!got && cyc < 40) begin step(); cyc++; got = if_done; end
        if_req = 1'b0;
        tests_run++;
        if (!got || cyc != 5) begin
            tests_failed++;
            $display("FAIL %s fetch latency: got %0d cycles (seen=%0b) expected 5", tag, cyc, got);
        end
        tests_run++;
        if (if_inst !== exp) begin
            tests_failed++;
            $display("FAIL %s fetch data: got %h expected %h", tag, if_inst, exp);
        end
        step();
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [5:0] op, input logic [31:0] dat, input string tag);
        int nb;
        int start;
        int cyc;
        bit got;
        bit ok;
        nb    = op_len(op);
        start = wr_a_log.size();
        cyc   = 0;
        got   = 0;
        ok    = 1;
        lsb_store = 1'b1; store_address = addr; data_store = dat; op_type_store = op;
        while (!got && cyc < 40) begin step(); cyc++; got = finish_store; end
        lsb_store = 1'b0;
        tests_run++;
        if (!got || cyc != nb + 1) begin
            tests_failed++;
            $display("FAIL %s store latency: got %0d cycles (seen=%0b) expected %0d", tag, cyc, got, nb + 1);
        end
        tests_run++;
        if (wr_a_log.size() - start != nb) ok = 0;
        else
            for (int i = 0; i < nb; i++)
                if (wr_a_log[start + i] !== addr + 32'(i) || wr_d_log[start + i] !== 8'(dat >> (8 * i))) ok = 0;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s store bytes: got %0d writes expected %0d correct writes at %h", tag, wr_a_log.size() - start, nb, addr);
        end
        for (int i = 0; i < nb; i++) ram[ram_idx(addr + 32'(i))] = 8'(dat >> (8 * i));
        step();
        tests_run++;
        if (finish_store !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s finish_store width: got %b expected 0", tag, finish_store);
        end
    endtask

    task automatic test_reset(input string tag);
        rst_in = 1'b1;
        lsb_load = 1'b1; load_address = $urandom; op_type_load = OP_LW; if_req = 1'b1;
        step(); step();
        tests_run++;
        if ({mem_wr, finish_load, finish_store, if_done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL %s pulses: got %b expected 0000", tag, {mem_wr, finish_load, finish_store, if_done});
        end
        tests_run++;
        if (mem_a !== 32'd0 || mem_dout !== 8'd0) begin
            tests_failed++;
            $display("FAIL %s mem port: got a=%h dout=%h expected 0", tag, mem_a, mem_dout);
        end
        tests_run++;
        if (data_load !== 32'd0 || if_inst !== 32'd0) begin
            tests_failed++;
            $display("FAIL %s data: got load=%h inst=%h expected 0", tag, data_load, if_inst);
        end
        lsb_load = 1'b0; if_req = 1'b0; rst_in = 1'b0;
        step();
        tests_run++;
        if (mem_a !== 32'd0 || finish_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s idle after reset: got a=%h fin=%b expected 0", tag, mem_a, finish_load);
        end
    endtask

    task automatic test_lw_basic();
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        lsb_load = 1'b1; load_address = 32'h100; op_type_load = OP_LW;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i <= 4) begin
                tests_run++;
                if (mem_a !== 32'h100 + 32'(i - 1)) begin
                    tests_failed++;
                    $display("FAIL lw_addr step %0d: got %h expected %h", i, mem_a, 32'h100 + 32'(i - 1));
                end
            end
            tests_run++;
            if (finish_load !== 1'(i == 5)) begin
                tests_failed++;
                $display("FAIL lw_finish step %0d: got %b expected %b", i, finish_load, i == 5);
            end
        end
        lsb_load = 1'b0;
        tests_run++;
        if (data_load !== 32'h44332211) begin
            tests_failed++;
            $display("FAIL lw_data: got %h expected 44332211", data_load);
        end
        step();
    endtask

    task automatic test_load_ext();
        ram[32'h200] = 8'h80;
        ram[32'h210] = 8'h34; ram[32'h211] = 8'h92;
        run_load(32'h200, OP_LB, "lb");
        tests_run++;
        if (data_load !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_const: got %h expected ffffff80", data_load); end
        run_load(32'h200, OP_LBU, "lbu");
        tests_run++;
        if (data_load !== 32'h00000080) begin tests_failed++; $display("FAIL lbu_const: got %h expected 00000080", data_load); end
        run_load(32'h210, OP_LH, "lh");
        tests_run++;
        if (data_load !== 32'hFFFF9234) begin tests_failed++; $display("FAIL lh_const: got %h expected ffff9234", data_load); end
        run_load(32'h210, OP_LHU, "lhu");
        run_load(32'h211, OP_LW, "lw_misaligned");
    endtask

    task automatic test_priority();
        int start;
        int cyc;
        bit got;
        bit saw_other;
        logic [31:0] exp;
        start = wr_a_log.size();
        cyc = 0; got = 0; saw_other = 0;
        lsb_store = 1'b1; store_address = 32'h40; data_store = 32'hDEADBEEF; op_type_store = OP_SW;
        lsb_load = 1'b1; load_address = 32'h80; op_type_load = OP_LW;
        if_req = 1'b1; if_addr = 32'hC0;
        while (!got && cyc < 40) begin
            step(); cyc++; got = finish_store;
            if (finish_load || if_done) saw_other = 1;
        end
        lsb_store = 1'b0;
        tests_run++;
        if (!got || cyc != 5 || saw_other) begin
            tests_failed++;
            $display("FAIL prio_store: got %0d cycles other=%b expected 5 cycles store first", cyc, saw_other);
        end
        tests_run++;
        if (wr_a_log.size() - start != 4 ||
            wr_a_log[start] !== 32'h40 || wr_d_log[start] !== 8'hEF ||
            wr_a_log[start + 1] !== 32'h41 || wr_d_log[start + 1] !== 8'hBE ||
            wr_a_log[start + 2] !== 32'h42 || wr_d_log[start + 2] !== 8'hAD ||
            wr_a_log[start + 3] !== 32'h43 || wr_d_log[start + 3] !== 8'hDE) begin
            tests_failed++;
            $display("FAIL prio_bytes: got %0d writes expected EF,BE,AD,DE at 0x40..0x43", wr_a_log.size() - start);
        end
        ram[32'h40] = 8'hEF; ram[32'h41] = 8'hBE; ram[32'h42] = 8'hAD; ram[32'h43] = 8'hDE;
        exp = model_load(32'h80, 4, 1'b0);
        cyc = 0; got = 0; saw_other = 0;
        while (!got && cyc < 40) begin
            step(); cyc++; got = finish_load;
            if (if_done) saw_other = 1;
        end
        lsb_load = 1'b0;
        tests_run++;
        if (!got || cyc != 6 || saw_other || data_load !== exp) begin
            tests_failed++;
            $display("FAIL prio_load: got %0d cycles data %h fetch=%b expected 6 cycles data %h", cyc, data_load, saw_other, exp);
        end
        exp = model_load(32'hC0, 4, 1'b0);
        cyc = 0; got = 0;
        while (!got && cyc < 40) begin step(); cyc++; got = if_done; end
        if_req = 1'b0;
        tests_run++;
        if (!got || cyc != 6 || if_inst !== exp) begin
            tests_failed++;
            $display("FAIL prio_fetch: got %0d cycles inst %h expected 6 cycles inst %h", cyc, if_inst, exp);
        end
        step();
    endtask

    task automatic test_io_stall();
        lsb_store = 1'b1; store_address = 32'h00030000; data_store = 32'h000000A5; op_type_store = OP_SB;
        io_buffer_full = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if (mem_wr !== 1'b0) begin tests_failed++; $display("FAIL io_hold step %0d: got mem_wr %b expected 0", i, mem_wr); end
        end
        io_buffer_full = 1'b0;
        step();
        tests_run++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h00030000 || mem_dout !== 8'hA5) begin
            tests_failed++;
            $display("FAIL io_write: got wr=%b a=%h d=%h expected 1 00030000 a5", mem_wr, mem_a, mem_dout);
        end
        step();
        lsb_store = 1'b0;
        tests_run++;
        if (finish_store !== 1'b1 || mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL io_finish: got fin=%b wr=%b expected 1 0", finish_store, mem_wr);
        end
        ram[ram_idx(32'h00030000)] = 8'hA5;
        step();
        // Outside the IO region a full buffer must not stall.
        io_buffer_full = 1'b1;
        run_store(32'h00020010, OP_SB, 32'h0000005A, "nonio_full");
        io_buffer_full = 1'b0;
    endtask

    task automatic test_rollback_fetch();
        int cyc;
        bit got;
        bit saw_if;
        logic [31:0] exp;
        if_req = 1'b1; if_addr = 32'h500;
        step(); step();
        roll_back = 1'b1; if_req = 1'b0;
        step();
        roll_back = 1'b0;
        exp = model_load(32'h600, 4, 1'b0);
        cyc = 0; got = 0; saw_if = 0;
        lsb_load = 1'b1; load_address = 32'h600; op_type_load = OP_LW;
        while (!got && cyc < 40) begin
            step(); cyc++; got = finish_load;
            if (if_done) saw_if = 1;
        end
        lsb_load = 1'b0;
        tests_run++;
        if (saw_if) begin tests_failed++; $display("FAIL rb_fetch_done: got if_done 1 expected 0"); end
        tests_run++;
        if (!got || cyc != 5 || data_load !== exp) begin
            tests_failed++;
            $display("FAIL rb_idle_next: got %0d cycles data %h expected 5 cycles data %h", cyc, data_load, exp);
        end
        step();
        // A request presented together with roll_back is not accepted.
        exp = model_load(32'h700, 4, 1'b0);
        cyc = 0; got = 0;
        roll_back = 1'b1; lsb_load = 1'b1; load_address = 32'h700; op_type_load = OP_LW;
        step(); cyc++;
        roll_back = 1'b0;
        while (!got && cyc < 40) begin step(); cyc++; got = finish_load; end
        lsb_load = 1'b0;
        tests_run++;
        if (!got || cyc != 6 || data_load !== exp) begin
            tests_failed++;
            $display("FAIL rb_same_cycle: got %0d cycles data %h expected 6 cycles data %h", cyc, data_load, exp);
        end
        step();
    endtask

    task automatic test_rollback_store();
        int start;
        int cyc;
        bit got;
        bit ok;
        logic [31:0] dat;
        dat = $urandom;
        start = wr_a_log.size();
        cyc = 0; got = 0; ok = 1;
        lsb_store = 1'b1; store_address = 32'h1000; data_store = dat; op_type_store = OP_SW;
        while (!got && cyc < 40) begin
            roll_back = 1'(cyc == 2);
            step(); cyc++; got = finish_store;
        end
        roll_back = 1'b0;
        lsb_store = 1'b0;
        tests_run++;
        if (!got || cyc != 5) begin
            tests_failed++;
            $display("FAIL rb_store_finish: got %0d cycles (seen=%0b) expected 5", cyc, got);
        end
        tests_run++;
        if (wr_a_log.size() - start != 4) ok = 0;
        else
            for (int i = 0; i < 4; i++)
                if (wr_a_log[start + i] !== 32'h1000 + 32'(i) || wr_d_log[start + i] !== 8'(dat >> (8 * i))) ok = 0;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rb_store_bytes: got %0d writes expected 4 bytes of %h", wr_a_log.size() - start, dat);
        end
        for (int i = 0; i < 4; i++) ram[ram_idx(32'h1000 + 32'(i))] = 8'(dat >> (8 * i));
        step();
    endtask

    task automatic test_rdy_stall();
        int cyc;
        bit got;
        logic [31:0] exp;
        exp = model_load(32'h300, 4, 1'b0);
        lsb_load = 1'b1; load_address = 32'h300; op_type_load = OP_LW;
        step(); step();
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (mem_a !== 32'h301 || finish_load !== 1'b0) begin
                tests_failed++;
                $display("FAIL rdy_freeze %0d: got a=%h fin=%b expected 00000301 0", i, mem_a, finish_load);
            end
        end
        rdy_in = 1'b1;
        cyc = 4; got = 0;
        while (!got && cyc < 40) begin step(); cyc++; got = finish_load; end
        lsb_load = 1'b0;
        tests_run++;
        if (!got || cyc != 7 || data_load !== exp) begin
            tests_failed++;
            $display("FAIL rdy_delay: got %0d cycles data %h expected 7 cycles data %h", cyc, data_load, exp);
        end
        rdy_in = 1'b0;
        step();
        tests_run++;
        if (finish_load !== 1'b1) begin tests_failed++; $display("FAIL rdy_pulse_hold: got %b expected 1", finish_load); end
        rdy_in = 1'b1;
        step();
        tests_run++;
        if (finish_load !== 1'b0) begin tests_failed++; $display("FAIL rdy_pulse_drop: got %b expected 0", finish_load); end
    endtask

    task automatic test_wrap();
        run_load(32'hFFFFFFFE, OP_LW, "wrap_lw");
        run_store(32'hFFFFFFFF, OP_SH, $urandom, "wrap_sh");
        run_fetch(32'hFFFFFFFD, "wrap_fetch");
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = $urandom;
            if (kind == 0)      run_load(a, load_ops[$urandom_range(0, 4)], "rand_load");
            else if (kind == 1) run_store(a, store_ops[$urandom_range(0, 2)], $urandom, "rand_store");
            else                run_fetch(a, "rand_fetch");
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        lsb_load = 1'b0; load_address = 32'd0; op_type_load = 6'd0;
        lsb_store = 1'b0; store_address = 32'd0; data_store = 32'd0; op_type_store = 6'd0;
        io_buffer_full = 1'b0;
        for (int i = 0; i < RAM_SZ; i++) ram[i] = 8'($urandom);

        test_reset("reset");
        test_lw_basic();
        test_load_ext();
        test_priority();
        test_io_stall();
        test_rollback_fetch();
        test_rollback_store();
        test_rdy_stall();
        test_wrap();
        test_random();
        test_reset("reset_again");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
